// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 stream control blocks.
// Digest bytes are numbered from the most significant end of the hash word.
package sha256_ctrl_pkg;

  localparam int DATA_W       = 8;
  localparam int DIGEST_BYTES = 32;
  localparam int DIGEST_W     = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_WAIT,
    ST_DUMP
  } state_t;

  // Byte 0 is the top byte of the digest.
  function automatic logic [DATA_W-1:0] digest_byte(input logic [DIGEST_W-1:0] h,
                                                    input logic [4:0]          idx);
    return h[DATA_W*(DIGEST_BYTES-1-int'(idx)) +: DATA_W];
  endfunction

endpackage

// File: rtl/sha256_stream_arbiter_if.sv
// Signal bundle between the two byte requesters, the SHA-256 core and the
// digest consumer; the arbiter sits on the slave side.
interface sha256_stream_arbiter_if;
  import sha256_ctrl_pkg::*;

  logic                req0_valid;
  logic [DATA_W-1:0]   req0_data;
  logic                req0_last;
  logic                req0_ready;
  logic                req1_valid;
  logic [DATA_W-1:0]   req1_data;
  logic                req1_last;
  logic                req1_ready;
  logic                core_start;
  logic [DATA_W-1:0]   core_data;
  logic                core_valid;
  logic                core_last;
  logic                core_in_ready;
  logic [DIGEST_W-1:0] core_hash;
  logic                core_done;
  logic                dig_valid;
  logic [DATA_W-1:0]   dig_byte;
  logic                dig_id;
  logic                dig_last;
  logic                dig_ready;
  logic                busy;
  logic                owner;
  logic                err;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  core_in_ready, core_hash, core_done, dig_ready,
    output req0_ready, req1_ready,
    output core_start, core_data, core_valid, core_last,
    output dig_valid, dig_byte, dig_id, dig_last,
    output busy, owner, err
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output core_in_ready, core_hash, core_done, dig_ready,
    input  req0_ready, req1_ready,
    input  core_start, core_data, core_valid, core_last,
    input  dig_valid, dig_byte, dig_id, dig_last,
    input  busy, owner, err
  );

endinterface

// File: rtl/sha256_stream_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// whichever requester was not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ~last_owner : req[1];
  end

endmodule

// File: rtl/sha256_stream_arbiter.sv
// Shares one streaming SHA-256 core between two byte requesters, holding each
// grant from the first message byte through the 32-byte digest readback.
module sha256_stream_arbiter
  import sha256_ctrl_pkg::*;
#(
  parameter int DONE_TIMEOUT = 4096
) (
  input logic                    clk,
  input logic                    rst,
  sha256_stream_arbiter_if.slave bus
);

  localparam int              TO_W    = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [4:0]      IDX_END = 5'(DIGEST_BYTES - 1);

  state_t              state_q, state_d;
  logic                owner_q;
  logic                last_owner_q;
  logic [4:0]          idx_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic                err_q;
  logic [DIGEST_W-1:0] hash_q;

  logic              gnt_valid, gnt_id;
  logic              own_valid, own_last;
  logic [DATA_W-1:0] own_data;
  logic              feed_last, wait_done, wait_timeout, dig_fire;

  rr_arb2 u_arb (
    .req        ({bus.req1_valid, bus.req0_valid}),
    .last_owner (last_owner_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign own_valid = owner_q ? bus.req1_valid : bus.req0_valid;
  assign own_data  = owner_q ? bus.req1_data  : bus.req0_data;
  assign own_last  = owner_q ? bus.req1_last  : bus.req0_last;

  // A completed digest takes priority over a timeout landing in the same cycle.
  assign feed_last    = (state_q == ST_FEED) && own_valid && bus.core_in_ready && own_last;
  assign wait_done    = (state_q == ST_WAIT) && bus.core_done;
  assign wait_timeout = (state_q == ST_WAIT) && !bus.core_done && (to_cnt_q == TO_LAST);
  assign dig_fire     = (state_q == ST_DUMP) && bus.dig_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_valid) state_d = ST_START;
      ST_START: state_d = ST_FEED;
      ST_FEED:  if (feed_last) state_d = ST_WAIT;
      ST_WAIT:  begin
        if (wait_done)         state_d = ST_DUMP;
        else if (wait_timeout) state_d = ST_IDLE;
      end
      ST_DUMP:  if (dig_fire && (idx_q == IDX_END)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.core_start = 1'b0;
    bus.core_data  = '0;
    bus.core_valid = 1'b0;
    bus.core_last  = 1'b0;
    bus.dig_valid  = 1'b0;
    bus.dig_byte   = '0;
    bus.dig_id     = 1'b0;
    bus.dig_last   = 1'b0;
    bus.busy       = (state_q != ST_IDLE);
    bus.owner      = owner_q;
    bus.err        = err_q;
    case (state_q)
      ST_START: bus.core_start = 1'b1;
      ST_FEED:  begin
        bus.core_valid = own_valid;
        bus.core_data  = own_data;
        bus.core_last  = own_last;
        if (owner_q) bus.req1_ready = bus.core_in_ready;
        else         bus.req0_ready = bus.core_in_ready;
      end
      ST_DUMP:  begin
        bus.dig_valid = 1'b1;
        bus.dig_byte  = digest_byte(hash_q, idx_q);
        bus.dig_id    = owner_q;
        bus.dig_last  = (idx_q == IDX_END);
      end
      default: ;
    endcase
  end

  // Control registers; last_owner starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      idx_q        <= '0;
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= wait_timeout;
      if ((state_q == ST_IDLE) && gnt_valid) owner_q <= gnt_id;
      if (wait_timeout || (dig_fire && (idx_q == IDX_END))) last_owner_q <= owner_q;
      if (wait_done)     idx_q <= '0;
      else if (dig_fire) idx_q <= idx_q + 5'd1;
      if (feed_last)                                          to_cnt_q <= '0;
      else if ((state_q == ST_WAIT) && (to_cnt_q != TO_LAST)) to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wait_done) hash_q <= bus.core_hash;
  end

endmodule

// File: tb/tb_sha256_stream_arbiter.sv
// Directed bench for sha256_stream_arbiter: a small core model, two requester
// drivers and a digest scoreboard fed as each message is issued.
module tb_sha256_stream_arbiter;
  import sha256_ctrl_pkg::*;

  typedef logic [7:0] msg_t[$];
  typedef struct packed {logic id; logic last; logic [7:0] b;} exp_t;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_stream_arbiter_if bus();

  sha256_stream_arbiter #(.DONE_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0, errors = 0, cyc = 0;
  exp_t sb[$];
  int   starts = 0, xfers = 0, last_xfer_cyc = 0, start_cyc = 0, done_cyc = 0;
  int   err_count = 0, err_cyc = 0, dig_idx = 0, first_dig_cyc = 0, hold_left = 0;
  bit   core_mute = 0, stray_pulse = 0, rdy_pat_en = 0, mon_ignore = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: bound expired, observed no event expected one", tag);
  endtask

  function automatic logic [26:0] outs();
    return {bus.req0_ready, bus.req1_ready, bus.core_start, bus.core_data, bus.core_valid,
            bus.core_last, bus.dig_valid, bus.dig_byte, bus.dig_id, bus.dig_last,
            bus.busy, bus.owner, bus.err};
  endfunction

  function automatic logic [255:0] digest_of(input msg_t m);
    logic [7:0]   acc;
    logic [255:0] d;
    if (m.size() == 3 && m[0] == 8'h61 && m[1] == 8'h62 && m[2] == 8'h63) return ABC_DIGEST;
    acc = 8'h5A;
    foreach (m[i]) acc = {acc[6:0], acc[7]} ^ m[i];
    d = '0;
    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = acc + 8'(i * 29) + 8'(m.size());
    return d;
  endfunction

  task automatic push_exp(input logic id, input msg_t m);
    logic [255:0] d;
    exp_t e;
    d = digest_of(m);
    for (int i = 0; i < 32; i++) begin
      e.id = id; e.last = (i == 31); e.b = d[255-8*i -: 8];
      sb.push_back(e);
    end
  endtask

  task automatic drive(input logic id, input logic v, input logic [7:0] d, input logic l);
    if (id) begin bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l; end
    else    begin bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l; end
  endtask

  task automatic send(input logic id, input msg_t m, input string tag);
    logic acc;
    int   w;
    for (int i = 0; i < m.size(); i++) begin
      drive(id, 1'b1, m[i], i == m.size() - 1);
      w = 0;
      forever begin
        @(negedge clk);
        acc = id ? bus.req1_ready : bus.req0_ready;
        @(posedge clk); #1;
        if (acc) break;
        w++;
        if (w > 2000) begin
          fail({tag, "_send"});
          drive(id, 1'b0, 8'h00, 1'b0);
          return;
        end
      end
    end
    drive(id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) begin ok = 1; break; end
    end
    if (!ok) fail({tag, "_drain"});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial forever @(posedge clk) cyc++;
  initial forever begin
    @(negedge clk);
    if (bus.err) begin err_count++; err_cyc = cyc; end
  end

  // Core model: records accepted bytes and answers three cycles after the last one.
  initial begin
    msg_t       rx;
    int         done_wait, pat_i;
    logic [3:0] pat;
    done_wait = 0; pat_i = 0; pat = 4'b1001;
    bus.core_done = 1'b0; bus.core_hash = '0; bus.core_in_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) done_wait = 0;
      if (bus.core_start) begin starts++; start_cyc = cyc; rx.delete(); end
      if (bus.core_valid) begin
        check("ready_mirror", 32'(bus.owner ? bus.req1_ready : bus.req0_ready), 32'(bus.core_in_ready));
        check("nonowner_ready", 32'(bus.owner ? bus.req0_ready : bus.req1_ready), 0);
      end
      if (!bus.busy) check("idle_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
      if (bus.core_valid && bus.core_in_ready) begin
        rx.push_back(bus.core_data);
        xfers++;
        if (bus.core_last) begin done_wait = 3; last_xfer_cyc = cyc; end
      end
      @(posedge clk); #1;
      bus.core_done = 1'b0;
      if (stray_pulse) begin
        bus.core_done = 1'b1; bus.core_hash = {8{32'hDEADBEEF}}; stray_pulse = 0;
      end else if (done_wait > 0) begin
        done_wait--;
        if (done_wait == 0 && !core_mute) begin
          bus.core_done = 1'b1; bus.core_hash = digest_of(rx); done_cyc = cyc;
        end
      end
      if (rdy_pat_en) begin bus.core_in_ready = pat[pat_i]; pat_i = (pat_i + 1) % 4; end
      else begin bus.core_in_ready = 1'b1; pat_i = 0; end
    end
  end

  // Digest monitor: scoreboard pops on handshake, holds checked while stalled.
  initial begin
    bit   held;
    exp_t hv, e, cur;
    held = 0; hv = '0;
    bus.dig_ready = 1'b1;
    forever begin
      @(negedge clk);
      cur = {bus.dig_id, bus.dig_last, bus.dig_byte};
      if (mon_ignore) begin
        sb.delete(); dig_idx = 0; held = 0;
      end else if (bus.dig_valid) begin
        if (dig_idx == 0 && !held) first_dig_cyc = cyc;
        if (held) check("dig_stable", 32'(cur), 32'(hv));
        if (bus.dig_ready) begin
          check("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("dig_byte", 32'(bus.dig_byte), 32'(e.b));
            check("dig_id", 32'(bus.dig_id), 32'(e.id));
            check("dig_last", 32'(bus.dig_last), 32'(e.last));
          end
          held = 0;
          dig_idx = bus.dig_last ? 0 : dig_idx + 1;
        end else begin
          held = 1; hv = cur;
        end
      end else if (held) begin
        check("dig_valid_held", 32'(bus.dig_valid), 1);
        held = 0;
      end
      @(posedge clk); #1;
      if (hold_left > 0 && dig_idx == 7 && bus.dig_valid) begin
        bus.dig_ready = 1'b0; hold_left--;
      end else bus.dig_ready = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    msg_t ma, mb, abc;
    int   s0, x0, e0, rc;
    bit   ok;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", 32'(outs()), 0);

    // Single requester "abc"
    abc = {8'h61, 8'h62, 8'h63};
    s0 = starts; x0 = xfers; rc = cyc;
    push_exp(1'b0, abc);
    send(1'b0, abc, "abc");
    wait_idle("abc");
    check("abc_starts", starts - s0, 1);
    check("abc_xfers", xfers - x0, 3);
    check("abc_grant_latency", start_cyc - rc, 1);
    check("abc_done_to_dig", first_dig_cyc - done_cyc, 1);

    // Core and digest backpressure
    ma = {};
    for (int i = 0; i < 8; i++) ma.push_back(8'(8'h10 + i));
    s0 = starts; x0 = xfers;
    rdy_pat_en = 1; hold_left = 5;
    push_exp(1'b0, ma);
    send(1'b0, ma, "bp");
    wait_idle("bp");
    rdy_pat_en = 0;
    check("bp_starts", starts - s0, 1);
    check("bp_xfers", xfers - x0, 8);
    check("bp_hold_used", hold_left, 0);

    // Stray done during FEED
    mb = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    x0 = xfers;
    push_exp(1'b1, mb);
    fork
      send(1'b1, mb, "stray");
      begin
        ok = 0;
        for (int n = 0; n < 50; n++) begin
          @(negedge clk);
          if (xfers >= x0 + 2) begin ok = 1; break; end
        end
        if (!ok) fail("stray_feed");
        stray_pulse = 1;
      end
    join
    wait_idle("stray");
    check("stray_xfers", xfers - x0, 6);

    // Contention after reset: req0, req1, then req0 first again
    do_reset();
    check("reset2_outputs", 32'(outs()), 0);
    ma = {8'h01, 8'h02, 8'h03, 8'h04};
    mb = {8'h11, 8'h12, 8'h13};
    push_exp(1'b0, ma); push_exp(1'b1, mb);
    fork send(1'b0, ma, "cont0"); send(1'b1, mb, "cont1"); join
    wait_idle("cont_a");
    ma = {8'h21}; mb = {8'h31, 8'h32};
    push_exp(1'b0, ma); push_exp(1'b1, mb);
    fork send(1'b0, ma, "cont2"); send(1'b1, mb, "cont3"); join
    wait_idle("cont_b");

    // Timeout: core never answers
    core_mute = 1; e0 = err_count;
    ma = {8'h55, 8'h66};
    send(1'b0, ma, "to");
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (err_count != e0) begin ok = 1; break; end
    end
    if (!ok) fail("to_err");
    core_mute = 0;
    check("to_err_delay", err_cyc - last_xfer_cyc, 17);
    check("to_busy", 32'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1 check("to_err_once", err_count - e0, 1);
    ma = {8'h71, 8'h72}; mb = {8'h81};
    push_exp(1'b1, mb); push_exp(1'b0, ma);
    fork send(1'b0, ma, "to_next0"); send(1'b1, mb, "to_next1"); join
    wait_idle("to_next");

    // Reset mid-DUMP at idx 10, then a normal message
    mb = {8'h90, 8'h91, 8'h92, 8'h93, 8'h94};
    push_exp(1'b1, mb);
    send(1'b1, mb, "mid");
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (dig_idx == 10) begin ok = 1; break; end
    end
    if (!ok) fail("mid_idx10");
    #1 rst = 1'b1; mon_ignore = 1;
    @(posedge clk); #1 rst = 1'b0;
    check("mid_reset_outputs", 32'(outs()), 0);
    @(posedge clk); #1 mon_ignore = 0;
    s0 = starts;
    push_exp(1'b0, abc);
    send(1'b0, abc, "post_reset");
    wait_idle("post_reset");
    check("post_reset_starts", starts - s0, 1);

    check("sb_final_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_stream_arbiter.md
# sha256_stream_arbiter

Shares one streaming SHA-256 core between two byte-stream requesters, one whole message at a time. Grants are round-robin, and each grant is held from the first byte through the 32-byte digest readback. The block sits between the GPIO/host-side producers and the `sha256_processor` instance. It issues the core's start pulse, gates byte traffic to the core, latches the digest and serialises it back, tagged with the owner's ID.

## Interface
Parameters:
- `DONE_TIMEOUT`, 4096: cycles allowed in WAIT for `core_done` before the message is aborted.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous reset, active high.
- `reqN_valid` in 1 (N=0,1): requester N presents a byte.
- `reqN_data` in 8: requester N byte.
- `reqN_last` in 1: the byte is the final byte of the message.
- `reqN_ready` out 1: byte accepted this cycle when high with `reqN_valid`.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_data` out 8: byte to the core.
- `core_valid` out 1: byte strobe to the core.
- `core_last` out 1: last-byte flag to the core.
- `core_in_ready` in 1: the core can take a byte this cycle.
- `core_hash` in 256: core digest; byte 0 is bits [255:248].
- `core_done` in 1: digest valid pulse from the core.
- `dig_valid` out 1: digest byte available.
- `dig_byte` out 8: digest byte.
- `dig_id` out 1: requester that owns the digest.
- `dig_last` out 1: high on the 32nd digest byte.
- `dig_ready` in 1: digest consumer accepts the byte.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: current or most recent grantee.
- `err` out 1: one-cycle pulse on a WAIT timeout.

## Operation
- **States:** IDLE → START → FEED → WAIT → DUMP → IDLE.
- **IDLE:**
  - If exactly one `reqN_valid` is high, grant N.
  - If both are high, grant the requester that is not `last_owner`.
  - On a grant: load `owner`, go to START.
  - No `reqN_ready` is asserted in IDLE; the byte is held by the requester.
- **START:**
  - Assert `core_start` for this single cycle.
  - Go to FEED.
- **FEED:** combinational pass-through for the owner only:
  - `core_valid = req[owner]_valid`
  - `core_data = req[owner]_data`
  - `core_last = req[owner]_last`
  - `req[owner]_ready = core_in_ready`
  - The non-owner's ready stays 0.
- **FEED exit:** when a byte is transferred with `last` set (valid & ready & last), go to WAIT and clear the timeout counter.
- **WAIT:**
  - On `core_done`, latch `core_hash` into `hash_q`, clear `idx`, go to DUMP.
  - Otherwise increment the counter.
  - When the counter reaches `DONE_TIMEOUT-1`: pulse `err`, set `last_owner` = `owner`, go to IDLE.
- **DUMP:**
  - `dig_valid` = 1.
  - `dig_byte = hash_q[255-8*idx -: 8]`.
  - `dig_id` = `owner`.
  - `dig_last` = (`idx` == 31).
  - `dig_valid`, `dig_byte`, `dig_id` and `dig_last` stay stable until `dig_ready`.
  - On `dig_ready`: `idx`++. If `idx` was 31, set `last_owner` = `owner` and go to IDLE.
- **`core_done` outside WAIT** is ignored.
- **Width rules:**
  - `idx` is 5 bits, wraps only on exit.
  - The timeout counter is `$clog2(DONE_TIMEOUT)` bits and saturates at the compare.
- **Reset:** applies from any state. Returns to IDLE with all outputs 0, `owner` 0 and `last_owner` 1, so requester 0 wins the first tie. A message in flight is dropped and the core is re-started at the next grant.

## Timing
- Grant latency: a request seen in IDLE at cycle t gives START at t+1 (`core_start` high). FEED begins at t+2; the first possible byte transfer is in t+2.
- Byte path in FEED has zero latency; throughput is one byte per cycle while `core_in_ready` is high.
- `core_done` at cycle t gives the first `dig_valid` at t+1.
- With `dig_ready` tied high, the 32 digest bytes take t+1..t+32 and IDLE is entered at t+33.
- `busy` is registered from state: it rises the cycle after the grant decision and falls in the cycle after the final digest handshake or timeout.
- A single-byte message (`last` on the first byte) goes START → FEED → WAIT with one transfer.

## Structure
- **Shared package `sha256_ctrl_pkg`:**
  - state enum: `ST_IDLE`, `ST_START`, `ST_FEED`, `ST_WAIT`, `ST_DUMP`
  - `DIGEST_BYTES` = 32
  - `DIGEST_W` = 256
- **Sub-module `rr_arb2`:** a two-way round-robin picker (`req[1:0]`, `last_owner` → `gnt_valid`, `gnt_id`). It is purely combinational and reused by later multi-client blocks.
- **Top level:** the arbiter FSM, the 256-bit digest register and the counters live here.

## Test plan
- **Single requester:** req0 sends "abc" (0x61 0x62 0x63, last on 0x63) to a core model. Required:
  - one `core_start` pulse;
  - 3 core transfers;
  - 32 digest bytes starting 0xBA 0x78 0x16 0xBF, with `dig_id`=0 and `dig_last` on byte 32.
- **Contention:** req0 and req1 are both valid in IDLE after reset. Required:
  - req0 is served first and req1 second;
  - a following simultaneous request is then served req0 first again (alternation holds).
- **Backpressure:**
  - `core_in_ready` toggles 1,0,0,1 during FEED: no byte is duplicated or lost and `reqN_ready` mirrors it.
  - `dig_ready` low for 5 cycles at `idx`=7: `dig_byte` is held stable and 32 bytes are still delivered.
- **Timeout:** with `DONE_TIMEOUT`=16, the core never asserts `core_done`. Required: `err` pulses once, 16 cycles after WAIT entry, with no `dig_valid`; the next requester is granted.
- **Reset mid-DUMP:** assert `rst` at `idx`=10. Required: the cycle after, all outputs are 0 and the state is IDLE; the next message completes normally.
- **Stray done:** `core_done` pulsed during FEED is ignored; the digest is taken only from the done pulse in WAIT.
